// File: rtl/serial_comparator_ctrl.sv
// Serial magnitude comparator: steps one 2-bit compare slice across two WIDTH-bit operands, MSB first, with early exit.
// Optional SERIAL_CMP_SIGNED_EN: treat operands as two's complement (MSB slice sign bits inverted).
module serial_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic [1:0]       sa, sb;

    // The current slice always sits in the top two bits of the shift registers.
    always_comb begin
        sa = a_q[WIDTH-1 -: 2];
        sb = b_q[WIDTH-1 -: 2];
`ifdef SERIAL_CMP_SIGNED_EN
        if (idx_q == IW'(NSLICE - 1)) begin
            sa[1] = ~sa[1];
            sb[1] = ~sb[1];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(NSLICE - 1);
                    state_d = CMP;
                end
            end
            CMP: begin
                if (sa != sb) begin
                    gt_d    = (sa > sb);
                    lt_d    = (sa < sb);
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d   = a_q << 2;
                    b_d   = b_q << 2;
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign a_gt_b    = gt_q;
    assign a_eq_b    = eq_q;
    assign a_lt_b    = lt_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Bench for serial_comparator_ctrl: directed literal cases plus randomized traffic against a latency/result model.
module tb_serial_comparator_ctrl;

    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, busy;

    always #5 clk = ~clk;

    serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_gt_b   (a_gt_b),
        .a_eq_b   (a_eq_b),
        .a_lt_b   (a_lt_b),
        .busy     (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {gt,eq,lt} straight from arithmetic comparison.
    function automatic logic [2:0] golden(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_SIGNED_EN
        logic signed [WIDTH-1:0] sx, sy;
        sx = x;
        sy = y;
        return {sx > sy, sx == sy, sx < sy};
`else
        return {x > y, x == y, x < y};
`endif
    endfunction

    // Edges from accept to result: one plus leading equal slices, capped.
    function automatic int lat_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n = 0;
        for (int i = NSLICE - 1; i >= 0; i--) begin
            if (x[2*i +: 2] != y[2*i +: 2]) break;
            n++;
        end
        return (n + 1 > NSLICE) ? NSLICE : n + 1;
    endfunction

    // Transaction-level model: pending result plus edges remaining until it appears.
    logic       m_init  = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_valid = 1'b0;
    logic [2:0] m_res   = '0;
    int         m_left  = 0;
    int         n_acc   = 0;
    int         n_hs    = 0;
    int         n_drop  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            if (m_busy) n_drop++;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_left  = 0;
            m_init  = 1'b1;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                n_hs++;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_res  = golden(a, b);
            m_left = lat_k(a, b);
            n_acc++;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("cycle_outputs",
                  32'({in_ready, busy, out_valid, a_gt_b, a_eq_b, a_lt_b}),
                  32'({~m_busy, m_busy, m_valid, (m_valid ? m_res : 3'b000)}));
        end
    end

    task automatic new_pair();
        a = WIDTH'($urandom);
        case ($urandom % 3)
            0:       b = WIDTH'($urandom);
            1:       b = a;
            default: b = a ^ (WIDTH'(1) << ($urandom % WIDTH));
        endcase
    endtask

    // Present one pair from IDLE with out_ready high; pins latency and flags to literals.
    task automatic run_pair(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input int exp_lat, input logic [2:0] exp_flags);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_flags"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(exp_flags));
        @(posedge clk);
        #1;
        check({name, "_post_hs"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        int acc;
        int guard;
        int hs0;

        // Reset with in_valid asserted: must be ignored.
        in_valid = 1'b1;
        a        = 8'h11;
        b        = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check("reset_state", 32'({in_ready, busy, out_valid, a_gt_b, a_eq_b, a_lt_b}), 32'b100000);

        run_pair("eq_a5", 8'hA5, 8'hA5, 4, 3'b010);
`ifdef SERIAL_CMP_SIGNED_EN
        run_pair("msb_80_7f", 8'h80, 8'h7F, 1, 3'b001);
`else
        run_pair("msb_80_7f", 8'h80, 8'h7F, 1, 3'b100);
`endif
        run_pair("lsb_12_13", 8'h12, 8'h13, 4, 3'b001);
        run_pair("mid_3c_34", 8'h3C, 8'h34, 3, 3'b100);

        // Backpressure: result held, new request ignored, then handshake with in_valid also high.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'hF0;
        b         = 8'h0F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_rise", 32'({out_valid, a_gt_b, a_eq_b, a_lt_b}), 32'b1100);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            a        = 8'h01;
            b        = 8'h02;
            @(posedge clk);
            #1;
            check("bp_hold", 32'({in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b}), 32'b01100);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h22;
        b         = 8'h22;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_release", 32'({in_ready, busy, out_valid}), 32'b100);

        // Reset on the second CMP edge discards the pair.
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h56;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_reset", 32'({in_ready, busy, out_valid, a_gt_b, a_eq_b, a_lt_b}), 32'b100000);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("no_stale_result", 32'(out_valid), 32'd0);
        end
        run_pair("after_rst_01_00", 8'h01, 8'h00, 4, 3'b100);

        // Back-to-back with out_ready tied high.
        hs0      = n_hs;
        acc      = 0;
        guard    = 0;
        in_valid = 1'b1;
        while (acc < 16 && guard < 1000) begin
            if (in_ready) begin
                new_pair();
                acc++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        check("b2b_timeout", 32'(guard < 1000), 32'd1);
        repeat (NSLICE + 3) @(posedge clk);
        #1;
        check("b2b_handshakes", 32'(n_hs - hs0), 32'd16);

        // Random valid/ready traffic.
        repeat (400) begin
            in_valid  = ($urandom % 2) == 0;
            out_ready = ($urandom % 4) != 0;
            new_pair();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NSLICE + 4) @(posedge clk);
        #1;
        check("final_idle", 32'({in_ready, busy, out_valid}), 32'b100);
        check("accept_vs_handshake", 32'(n_acc - n_drop), 32'(n_hs));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
